// File: rtl/demux1xn_reg.sv
// -----------------------------------------------------------------------------
// demux1xn_reg
//
// Registered 1-to-N demultiplexer with a valid/ready handshake on each channel.
// Each input word goes to one of N_OUT holding registers, chosen by in_sel.
// Each channel holds one word. A channel that is not loaded keeps its data
// bits, so those bits do not toggle.
//
// Optional feature (macro DEMUX_ACT_CNT_EN):
//   - Adds one saturating bit-toggle counter per channel.
//   - The counters measure switching activity for power estimation.
//   - The macro adds the ports cnt_clr and act_cnt.
//
// Parameters:
//   WIDTH      data width per channel
//   N_OUT      number of output channels (2..16)
//   IDLE_ZERO  0: keep out_data after consumption, 1: clear it to 0
//   CNT_W      activity counter width (macro build only)
//   SEL_W      select width, derived from N_OUT
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    input word
//   in_sel     destination channel; values >= N_OUT drop the word
//   in_valid   input word valid
//   in_ready   block can accept (combinational, from in_sel/out_ready)
//   out_data   channel i occupies bits [i*WIDTH +: WIDTH]
//   out_valid  per-channel valid
//   out_ready  per-channel consumer ready
//   cnt_clr    synchronous clear of all activity counters (macro only)
//   act_cnt    per-channel toggle counts, CNT_W bits each (macro only)
//   err_sel    one-cycle pulse after a word with an out-of-range select is dropped
// -----------------------------------------------------------------------------
module demux1xn_reg #(
    parameter int  WIDTH     = 4,
    parameter int  N_OUT     = 4,
    parameter int  IDLE_ZERO = 0,
    parameter int  CNT_W     = 16,
    localparam int SEL_W     = $clog2(N_OUT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_OUT*WIDTH-1:0]   out_data,
    output logic [N_OUT-1:0]         out_valid,
    input  logic [N_OUT-1:0]         out_ready,
`ifdef DEMUX_ACT_CNT_EN
    input  logic                     cnt_clr,
    output logic [N_OUT*CNT_W-1:0]   act_cnt,
`endif
    output logic                     err_sel
);

    logic [N_OUT-1:0][WIDTH-1:0] data_p0;
    logic [N_OUT-1:0][WIDTH-1:0] data_nxt;
    logic [N_OUT-1:0]            vld_p0;
    logic [N_OUT-1:0]            load;
    logic [N_OUT-1:0]            wr;
    logic                        err_p0;
    logic                        sel_hit;
    logic                        tgt_free;
    logic                        accept;

    // A select that matches no channel leaves tgt_free at 1.
    // Such a word is accepted and then dropped, so the input never stalls.
    always_comb begin
        tgt_free = 1'b1;
        sel_hit  = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_hit  = 1'b1;
                tgt_free = !vld_p0[i] || out_ready[i];
            end
        end
    end

    assign in_ready = tgt_free;
    assign accept   = in_valid && tgt_free;

    // The data register is written on a load. With IDLE_ZERO set, it is
    // also written (cleared) when a valid word is consumed.
    always_comb begin
        load     = '0;
        wr       = '0;
        data_nxt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            load[i]     = accept && (in_sel == SEL_W'(i));
            wr[i]       = load[i] || (vld_p0[i] && out_ready[i] && (IDLE_ZERO != 0));
            data_nxt[i] = load[i] ? in_data : '0;
        end
    end

    // ---- stage p0: channel holding registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p0 <= '0;
            vld_p0  <= '0;
            err_p0  <= 1'b0;
        end else begin
            err_p0 <= accept && !sel_hit;
            for (int i = 0; i < N_OUT; i++) begin
                if (wr[i]) begin
                    data_p0[i] <= data_nxt[i];
                end
                // A load overrides a same-cycle consume, so out_valid stays high.
                vld_p0[i] <= load[i] || (vld_p0[i] && !out_ready[i]);
            end
        end
    end

    assign out_data  = data_p0;
    assign out_valid = vld_p0;
    assign err_sel   = err_p0;

`ifdef DEMUX_ACT_CNT_EN
    localparam int PW = $clog2(WIDTH + 1);
    localparam int MW = (PW > CNT_W) ? PW : CNT_W;

    logic [N_OUT-1:0][CNT_W-1:0] cnt_p0;

    function automatic logic [PW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int b = 0; b < WIDTH; b++) begin
            n = n + PW'(v[b]);
        end
        return n;
    endfunction

    // ~cnt equals the headroom left below the all-ones ceiling.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [PW-1:0]    inc);
        logic [CNT_W-1:0] room;
        room = ~cnt;
        if (MW'(inc) >= MW'(room)) begin
            return '1;
        end
        return cnt + CNT_W'(inc);
    endfunction

    // ---- stage p0: activity counters, tracking the data register writes ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (cnt_clr) begin
            cnt_p0 <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (wr[i]) begin
                    cnt_p0[i] <= sat_add(cnt_p0[i], popcnt(data_p0[i] ^ data_nxt[i]));
                end
            end
        end
    end

    assign act_cnt = cnt_p0;
`endif

endmodule

// File: tb/tb_demux1xn_reg.sv
module tb_demux1xn_reg;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int SW = 2;
    localparam int CW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W-1:0]     in_data = '0;
    logic [SW-1:0]    in_sel = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N*W-1:0]   out_data;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready = '1;
    logic             err_sel;
`ifdef DEMUX_ACT_CNT_EN
    logic             cnt_clr = 1'b0;
    logic [N*CW-1:0]  act_cnt;
    int               exp_cnt[N];
    logic [W-1:0]     reg_val[N];
`endif

    demux1xn_reg #(
        .WIDTH(W),
        .N_OUT(N),
        .IDLE_ZERO(0),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_sel(in_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef DEMUX_ACT_CNT_EN
        .cnt_clr(cnt_clr),
        .act_cnt(act_cnt),
`endif
        .err_sel(err_sel)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Reference model: an ordered list of words waiting on each channel.
    // last[] is the value a drained channel keeps showing.
    logic [W-1:0] q[N][$];
    logic [W-1:0] last[N];
    int           avail[N];
    bit           err_q[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int popc(input logic [W-1:0] v);
        int n = 0;
        for (int b = 0; b < W; b++) n += int'(v[b]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            last[i]  = '0;
            avail[i] = 0;
`ifdef DEMUX_ACT_CNT_EN
            exp_cnt[i] = 0;
            reg_val[i] = '0;
`endif
        end
        err_q.delete();
    endtask

    // Monitor: check the state registered at the last edge, then retire the
    // words the consumer takes at the coming edge.
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                avail[i] = q[i].size();
                chk($sformatf("out_valid[%0d]", i), out_valid[i], (q[i].size() != 0));
                chk($sformatf("out_data[%0d]", i), out_data[i*W +: W],
                    (q[i].size() != 0) ? q[i][0] : last[i]);
`ifdef DEMUX_ACT_CNT_EN
                chk($sformatf("act_cnt[%0d]", i), act_cnt[i*CW +: CW], exp_cnt[i]);
`endif
            end
            chk("err_sel", err_sel, (err_q.size() != 0) ? err_q.pop_front() : 1'b0);
        end
        #3;
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                if (avail[i] != 0 && out_ready[i]) last[i] = q[i].pop_front();
            end
        end
    end

    // Stimulus: drive one cycle and push the expected outcome into the model.
    task automatic cycle(input bit v, input int sel, input logic [W-1:0] d,
                         input logic [N-1:0] ordy, input bit clr);
        bit exp_rdy;
        bit acc;
        @(posedge clk);
        #2;
        in_valid  = v;
        in_sel    = SW'(sel);
        in_data   = d;
        out_ready = ordy;
`ifdef DEMUX_ACT_CNT_EN
        cnt_clr   = clr;
`endif
        #1;
        if (sel >= N) exp_rdy = 1'b1;
        else exp_rdy = (q[sel].size() == 0) || ordy[sel];
        chk("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        err_q.push_back(acc && (sel >= N));
        if (acc && sel < N) begin
            q[sel].push_back(d);
`ifdef DEMUX_ACT_CNT_EN
            exp_cnt[sel] += popc(reg_val[sel] ^ d);
            if (exp_cnt[sel] > (1 << CW) - 1) exp_cnt[sel] = (1 << CW) - 1;
            reg_val[sel] = d;
`endif
        end
`ifdef DEMUX_ACT_CNT_EN
        if (clr) for (int i = 0; i < N; i++) exp_cnt[i] = 0;
`else
        if (clr) in_data = d;
`endif
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst err_sel", err_sel, 0);
        chk("rst in_ready", in_ready, 1);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // basic steer
        cycle(1, 2, 4'b1101, 3'b111, 0);
        cycle(1, 1, 4'b0000, 3'b111, 0);
        cycle(0, 0, 4'b0000, 3'b111, 0);
        // backpressure on ch1, then release with a same-cycle reload
        cycle(1, 1, 4'b0100, 3'b101, 0);
        cycle(1, 1, 4'b0101, 3'b101, 0);
        cycle(1, 1, 4'b0101, 3'b111, 0);
        cycle(0, 0, 4'b0000, 3'b111, 0);
        // ch2 stalled and full, ch0 still flows
        cycle(1, 2, 4'b1010, 3'b011, 0);
        cycle(1, 0, 4'b1111, 3'b011, 0);
        cycle(0, 0, 4'b0000, 3'b011, 0);
        cycle(0, 0, 4'b0000, 3'b111, 0);
        // out-of-range selects, single and back-to-back
        cycle(1, 3, 4'b0111, 3'b111, 0);
        cycle(0, 0, 4'b0000, 3'b111, 0);
        cycle(1, 3, 4'b0110, 3'b111, 0);
        cycle(1, 3, 4'b1001, 3'b111, 0);
        cycle(0, 0, 4'b0000, 3'b111, 0);
        // toggle-count sequence on ch2, then clear
        cycle(1, 2, 4'b1101, 3'b111, 0);
        cycle(1, 2, 4'b0010, 3'b111, 0);
        cycle(1, 2, 4'b1101, 3'b111, 0);
        cycle(0, 0, 4'b0000, 3'b111, 1);
        cycle(0, 0, 4'b0000, 3'b111, 0);

        // reset while ch0 and ch2 hold words
        cycle(1, 0, 4'b0011, 3'b000, 0);
        cycle(1, 2, 4'b1001, 3'b000, 0);
        @(posedge clk);
        #2;
        mon_en   = 1'b0;
        in_valid = 1'b0;
        chk("pre-rst out_valid", out_valid, 3'b101);
        rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst out_data", out_data, 0);
        chk("async rst in_ready", in_ready, 1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // randomized traffic
        repeat (1500) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  W'($urandom_range(0, 15)), N'($urandom_range(0, 7)),
                  $urandom_range(0, 31) == 0);
        end
        repeat (3) cycle(0, 0, 4'b0000, 3'b111, 0);

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux1xn_reg.md
# demux1xn_reg

Parametrised, registered 1-to-N demultiplexer with per-channel valid/ready handshake, the pipelined successor to the combinational 1x4 demux in the power-estimation datapath. One input word is steered by a select field into one of N_OUT output holding registers. Unselected channels hold their last value, so they do not toggle. An optional per-channel bit-toggle counter reports the switching activity that feeds the power-estimation accumulators.

## Interface
Parameters:
- WIDTH, 4: data width per channel (>=1)
- N_OUT, 4: number of output channels (2..16)
- SEL_W, $clog2(N_OUT): select width (derived, not overridden)
- IDLE_ZERO, 0: 0 keeps out_data after consumption; 1 clears the channel's out_data to 0 on consumption
- CNT_W, 16: activity counter width (used only with DEMUX_ACT_CNT_EN)

Ports:
- clk  in  1  rising-edge clock, the block's only clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  input word
- in_sel  in  SEL_W  destination channel
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept (combinational)
- out_data  out  N_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- out_valid  out  N_OUT  per-channel valid
- out_ready  in  N_OUT  per-channel consumer ready
- err_sel  out  1  one-cycle pulse: accepted word had in_sel >= N_OUT
- cnt_clr  in  1  synchronous clear of activity counters (macro only)
- act_cnt  out  N_OUT*CNT_W  per-channel toggle count (macro only)

## Operation
- Each channel has one WIDTH-bit holding register and one valid flag. Depth is 1 per channel.
- Accept condition: in_valid && in_ready.
- in_ready = 1 when in_sel >= N_OUT. Otherwise in_ready = !out_valid[in_sel] || out_ready[in_sel].
- On accept to channel s < N_OUT: out_data[s] <= in_data and out_valid[s] <= 1.
- On accept with in_sel >= N_OUT: the word is dropped, no channel changes, and err_sel = 1 for the next cycle. This can only occur when N_OUT is not a power of two.
- Consumption of channel i: out_valid[i] && out_ready[i]. If channel i is not loaded in the same cycle, out_valid[i] <= 0, and out_data[i] holds (IDLE_ZERO=0) or clears to 0 (IDLE_ZERO=1).
- Load and consume on the same channel in the same cycle: the new word is loaded and out_valid stays 1, giving full throughput.
- Channels drain independently. A stalled channel never blocks words addressed to other channels.
- out_data and out_valid are driven only from registers. No input-to-output combinational path exists except in_ready.

## Timing
- Latency: an input accepted at edge k appears on out_data/out_valid after edge k.
- Throughput: one word per cycle while the target channel is empty or being consumed.
- Reset (async assert, released synchronously by the system): out_valid=0, out_data=0, err_sel=0, act_cnt=0. in_ready evaluates to 1 during and after reset.
- Reset mid-transfer: words held in channels are discarded and no out_valid survives.
- err_sel is high for exactly one cycle per dropped word.
- With back-to-back drops, err_sel stays high once per dropped word.

## Configuration
- Macro DEMUX_ACT_CNT_EN.
- Defined:
  - On every register write to channel i (load, or IDLE_ZERO clear), act_cnt[i] += popcount(old ^ new).
  - Counts saturate at 2^CNT_W-1.
  - cnt_clr zeroes all counters on the next edge and takes priority over a same-cycle increment.
  - Ports cnt_clr and act_cnt exist.
- Undefined: counters, cnt_clr and act_cnt are absent. Data-path behaviour is identical.

## Test plan
- Basic steer (WIDTH=4, N_OUT=4, all out_ready=1):
  - sel=2, data=1101 -> after 1 edge out_valid=0100 and ch2=1101.
  - next sel=1, data=0000 -> out_valid=0010 and ch2 still holds 1101.
- Backpressure: out_ready[1]=0; send 0100 then 0101 to ch1 -> first word held, in_ready=0 for the second; raising out_ready[1] accepts 0101 the same cycle with out_valid[1] continuously 1.
- Independent drain: ch3 stalled and full; send 1111 to ch0 -> accepted and appears on ch0 next cycle.
- Out-of-range (N_OUT=3): sel=3, data=0111 -> in_ready=1, err_sel pulses one cycle, out_valid stays 000, and no out_data changes.
- Reset mid-operation: assert rst while out_valid=1010 -> out_valid and out_data are 0 immediately, with no clock edge needed.
- Activity counter (macro defined, CNT_W=3):
  - ch2 loads 1101 then 0010 -> act_cnt[2] = 3 then 7.
  - a further load of 1101 keeps it at 7 (saturated).
  - cnt_clr -> 0.
